ng_scaler_gen: RTL
==================

Name: ng_scaler_gen

Overview:
Parametrised successor to the AGC clock scaler. A prescaler feeds a CNT_W-bit frequency chain (F01..Fn). NUM_TAPS independent channels each select any chain bit at run time and produce a one-cycle rising-edge pulse. Each pulse is held as a pending request with ACK handshake and overrun detection. A boot accelerator runs the chain at full rate after power-up; the block feeds PROC/TPG consumers (F10X/F13X/F17X-style timers, debounce ticks).

Parameters:
PRE_DIV, 10, prescaler divide ratio (≥2); one master tick every PRE_DIV enabled cycles
CNT_W, 17, frequency chain width
NUM_TAPS, 4, number of tap channels
TAP_SEL_W, 5, tap select width per channel
BOOT_W, 20, boot counter width
FAST_BOOT, 1, 1 = chain ticks every enabled cycle until BOOTED

Ports:
CLK_256K  in  1  clock
NPURST  in  1  reset, asynchronous, active-low
SCL_ENAB  in  1  scaler enable; 0 freezes prescaler and chain
CLR  in  1  synchronous clear of prescaler, chain, channel state
TAP_SEL  in  NUM_TAPS*TAP_SEL_W  channel i select = bits [i*TAP_SEL_W +: TAP_SEL_W]
TAP_EN  in  NUM_TAPS  per-channel pulse enable
ACK  in  NUM_TAPS  per-channel pending acknowledge
MASTER_TICK  out  1  combinational prescaler terminal count
FCNT  out  CNT_W  chain value
LEVEL  out  NUM_TAPS  selected chain bit per channel
PULSE  out  NUM_TAPS  registered one-cycle rising-edge pulse
PEND  out  NUM_TAPS  pending request
OVR  out  NUM_TAPS  sticky overrun
OVF  out  1  registered one-cycle chain wrap pulse
BOOTED  out  1  sticky boot-complete

Behaviour:
- Reset (NPURST=0, async): all registers and outputs 0; BOOTED=0.
- Boot counter: increments every cycle while BOOTED=0. BOOTED<=1 when count = 2^BOOT_W-1. Counter holds afterwards. CLR does not affect it.
- Prescaler Mcnt, 0..PRE_DIV-1:
  - If SCL_ENAB=0: Mcnt holds.
  - Else if FAST_BOOT and !BOOTED: Mcnt held 0, MASTER_TICK=1.
  - Else MASTER_TICK = (Mcnt==PRE_DIV-1); Mcnt <= tick ? 0 : Mcnt+1.
- Chain: on MASTER_TICK, FCNT <= FCNT+1 modulo 2^CNT_W. OVF=1 in the cycle after FCNT goes all-ones -> 0.
- LEVEL[i] = FCNT[sel_i] when sel_i < CNT_W, else 0 (out-of-range select disables the channel).
- Edge detect: each channel holds prev_i (last LEVEL) and sel_q_i (last select).
  - PULSE[i] <= TAP_EN[i] & LEVEL[i] & ~prev_i & (TAP_SEL_i == sel_q_i).
  - Latency: PULSE high in the cycle after FCNT shows the rising bit.
  - A select change never pulses; prev_i reloads that cycle.
  - TAP_EN=0 suppresses PULSE but prev_i still tracks LEVEL.
- PEND/OVR per channel, evaluated on the registered PULSE:
  - PULSE & !PEND: PEND<=1.
  - PULSE & PEND & ACK: PEND stays 1, no OVR (old request consumed, new one taken).
  - PULSE & PEND & !ACK: PEND stays 1, OVR<=1.
  - !PULSE & ACK: PEND<=0.
  - OVR clears only on CLR or reset.
- CLR (sync, highest priority after reset): Mcnt, FCNT, prev, PULSE, PEND, OVR, OVF <= 0. sel_q <= TAP_SEL. No pulse in the CLR cycle or the cycle after.
- SCL_ENAB deassert mid-count: FCNT and Mcnt freeze. Pending requests and handshakes keep working.
- A taps-equal-same-bit configuration is legal; channels are fully independent.

Decomposition:
- Package ng_scaler_pkg holds:
  - Default parameter constants.
  - Tap index constants TAP_F10=9, TAP_F13=12, TAP_F17=16.
  - A function tap_sel_ok(sel, CNT_W).
- One sub-module, ng_scaler_tap, instantiated NUM_TAPS times via generate. It holds one channel's select compare, edge detect, PEND/OVR handshake.

Test Plan:
1. PRE_DIV=4, CNT_W=6, FAST_BOOT=0: release reset with SCL_ENAB=1 -> MASTER_TICK at cycles 3,7,11,…; FCNT=1 after cycle 4; FCNT wraps 63->0 after 256 cycles with a single OVF pulse.
2. Tap0 sel=2, TAP_EN=1, ACK held 1 -> PULSE every 32 cycles (FCNT 3->4, 11->12…), exactly 1 cycle wide; PEND toggles per the handshake rules.
3. Tap1 sel=0, ACK=0 -> first PULSE sets PEND; second PULSE sets OVR=1; ACK in the same cycle as a PULSE keeps PEND=1 with no new OVR; CLR clears OVR and PEND.
4. Change tap2 select 0->3 while FCNT[3]=1 -> no PULSE; next genuine FCNT[3] rise pulses. Select 31 -> LEVEL=0, no pulses.
5. FAST_BOOT=1, BOOT_W=4 -> FCNT increments every cycle for 15 cycles, BOOTED=1 at cycle 15, then increments every PRE_DIV cycles. Reset mid-run clears BOOTED.
6. SCL_ENAB low for 20 cycles mid-count -> FCNT/Mcnt frozen, no PULSE. NPURST asserted mid-pending -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/ng_scaler_pkg.sv
// Shared constants and helpers for the generic AGC-style clock scaler.
package ng_scaler_pkg;

  localparam int unsigned DEF_PRE_DIV   = 10;
  localparam int unsigned DEF_CNT_W     = 17;
  localparam int unsigned DEF_NUM_TAPS  = 4;
  localparam int unsigned DEF_TAP_SEL_W = 5;
  localparam int unsigned DEF_BOOT_W    = 20;
  localparam int unsigned DEF_FAST_BOOT = 1;

  // Chain bit indices of the classic timer taps
  localparam int unsigned TAP_F10 = 9;
  localparam int unsigned TAP_F13 = 12;
  localparam int unsigned TAP_F17 = 16;

  function automatic logic tap_sel_ok(input int unsigned sel, input int unsigned cnt_w);
    return sel < cnt_w;
  endfunction

endpackage

// File: rtl/ng_scaler_tap.sv
// One scaler channel: chain-bit select, rising-edge pulse and PEND/OVR handshake.
module ng_scaler_tap
  import ng_scaler_pkg::*;
#(
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned TAP_SEL_W = DEF_TAP_SEL_W
) (
  input  logic                 CLK_256K,
  input  logic                 NPURST,
  input  logic                 clr,
  input  logic [CNT_W-1:0]     fcnt,
  input  logic [TAP_SEL_W-1:0] tap_sel,
  input  logic                 tap_en,
  input  logic                 ack,
  output logic                 level,
  output logic                 pulse,
  output logic                 pend,
  output logic                 ovr
);

  logic                 bit_c;
  logic                 prev;
  logic [TAP_SEL_W-1:0] sel_q;

  // Mux the selected chain bit; out-of-range selects read as 0
  always_comb begin
    bit_c = 1'b0;
    for (int unsigned b = 0; b < CNT_W; b++) begin
      if (32'(tap_sel) == b) bit_c = fcnt[b];
    end
  end

  assign level = bit_c & tap_sel_ok(32'(tap_sel), CNT_W);

  always_ff @(posedge CLK_256K or negedge NPURST) begin
    if (!NPURST) begin
      prev  <= 1'b0;
      sel_q <= '0;
      pulse <= 1'b0;
      pend  <= 1'b0;
      ovr   <= 1'b0;
    end else if (clr) begin
      prev  <= 1'b0;
      sel_q <= tap_sel;
      pulse <= 1'b0;
      pend  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      prev  <= level;
      sel_q <= tap_sel;
      // A select change reloads prev without pulsing
      pulse <= tap_en & level & ~prev & (tap_sel == sel_q);
      if (pulse) begin
        pend <= 1'b1;
        if (pend & ~ack) ovr <= 1'b1;
      end else if (ack) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ng_scaler_gen.sv
// Prescaled frequency chain with boot accelerator and NUM_TAPS pulse channels.
module ng_scaler_gen
  import ng_scaler_pkg::*;
#(
  parameter int unsigned PRE_DIV   = DEF_PRE_DIV,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned NUM_TAPS  = DEF_NUM_TAPS,
  parameter int unsigned TAP_SEL_W = DEF_TAP_SEL_W,
  parameter int unsigned BOOT_W    = DEF_BOOT_W,
  parameter int unsigned FAST_BOOT = DEF_FAST_BOOT
) (
  input  logic                          CLK_256K,
  input  logic                          NPURST,
  input  logic                          SCL_ENAB,
  input  logic                          CLR,
  input  logic [NUM_TAPS*TAP_SEL_W-1:0] TAP_SEL,
  input  logic [NUM_TAPS-1:0]           TAP_EN,
  input  logic [NUM_TAPS-1:0]           ACK,
  output logic                          MASTER_TICK,
  output logic [CNT_W-1:0]              FCNT,
  output logic [NUM_TAPS-1:0]           LEVEL,
  output logic [NUM_TAPS-1:0]           PULSE,
  output logic [NUM_TAPS-1:0]           PEND,
  output logic [NUM_TAPS-1:0]           OVR,
  output logic                          OVF,
  output logic                          BOOTED
);

  localparam int unsigned       MCNT_W    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(PRE_DIV - 1);

  logic [MCNT_W-1:0] mcnt;
  logic [BOOT_W-1:0] boot_cnt;
  logic              fast_c;

  assign fast_c      = (FAST_BOOT != 0) && !BOOTED;
  assign MASTER_TICK = SCL_ENAB & (fast_c | (mcnt == MCNT_LAST));

  // Power-up boot counter; immune to CLR
  always_ff @(posedge CLK_256K or negedge NPURST) begin
    if (!NPURST) begin
      boot_cnt <= '0;
      BOOTED   <= 1'b0;
    end else if (!BOOTED) begin
      if (boot_cnt == '1) BOOTED <= 1'b1;
      else                boot_cnt <= boot_cnt + BOOT_W'(1);
    end
  end

  always_ff @(posedge CLK_256K or negedge NPURST) begin
    if (!NPURST) begin
      mcnt <= '0;
    end else if (CLR) begin
      mcnt <= '0;
    end else if (SCL_ENAB) begin
      if (fast_c || MASTER_TICK) mcnt <= '0;
      else                       mcnt <= mcnt + MCNT_W'(1);
    end
  end

  // Frequency chain and registered wrap pulse
  always_ff @(posedge CLK_256K or negedge NPURST) begin
    if (!NPURST) begin
      FCNT <= '0;
      OVF  <= 1'b0;
    end else if (CLR) begin
      FCNT <= '0;
      OVF  <= 1'b0;
    end else begin
      OVF <= MASTER_TICK & (FCNT == '1);
      if (MASTER_TICK) FCNT <= FCNT + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
    ng_scaler_tap #(
      .CNT_W     (CNT_W),
      .TAP_SEL_W (TAP_SEL_W)
    ) u_tap (
      .CLK_256K (CLK_256K),
      .NPURST   (NPURST),
      .clr      (CLR),
      .fcnt     (FCNT),
      .tap_sel  (TAP_SEL[i*TAP_SEL_W +: TAP_SEL_W]),
      .tap_en   (TAP_EN[i]),
      .ack      (ACK[i]),
      .level    (LEVEL[i]),
      .pulse    (PULSE[i]),
      .pend     (PEND[i]),
      .ovr      (OVR[i])
    );
  end

endmodule
